// File: rtl/stream_to_hs_adapter.sv
// AXI-Stream receive side: filters packets by first-beat TID, buffers accepted beats
// in a small FIFO and presents the head to the HLS core as a 68-bit ap_hs word.
module stream_to_hs_adapter #(
  parameter int DEPTH     = 2,
  parameter int TID_WIDTH = 4,
  parameter int ACCID     = 0,
  parameter int CHECK_TID = 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [63:0]          inStream_tdata,
  input  logic [2:0]           inStream_tdest,
  input  logic [TID_WIDTH-1:0] inStream_tid,
  input  logic                 inStream_tlast,
  input  logic                 inStream_tvalid,
  output logic                 inStream_tready,
  output logic [67:0]          out_hs,
  output logic                 out_hs_ap_vld,
  input  logic                 out_hs_ap_ack,
  output logic [15:0]          drop_count,
  output logic                 tid_error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [TID_WIDTH-1:0] ACC_TID = TID_WIDTH'(ACCID);

  typedef enum logic {PASS = 1'b0, DROP = 1'b1} state_t;

  logic [67:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  state_t        state;
  logic          in_pkt;

  logic accept;
  logic tid_bad;
  logic drop_beat;
  logic push;
  logic pop;

  // Handshake: a beat transfers on tvalid&&tready; the head is consumed on ap_vld&&ap_ack.
  // tready never looks at tvalid, and while dropping it ignores FIFO occupancy.
  assign inStream_tready = aresetn && ((count < FULL) || (state == DROP));
  assign accept          = inStream_tvalid && inStream_tready;
  assign tid_bad         = (CHECK_TID != 0) && (inStream_tid != ACC_TID);
  assign drop_beat       = accept && ((state == DROP) || (!in_pkt && tid_bad));
  assign push            = accept && !drop_beat;
  assign pop             = out_hs_ap_vld && out_hs_ap_ack;

  assign out_hs        = mem[rd_ptr];
  assign out_hs_ap_vld = (count != '0);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= PASS;
      in_pkt     <= 1'b0;
      drop_count <= '0;
      tid_error  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {inStream_tdata, inStream_tdest, inStream_tlast};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      if (accept) in_pkt <= !inStream_tlast;

      // Only a mismatched first beat that is not also the last beat opens a drop window.
      case (state)
        PASS:    if (drop_beat && !inStream_tlast) state <= DROP;
        DROP:    if (accept && inStream_tlast) state <= PASS;
        default: state <= PASS;
      endcase

      if (drop_beat) begin
        tid_error <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule
